ccg_en_ctrl: RTL and testbench
==============================

# ccg_en_ctrl

Clock-gate enable controller that sits in front of one `generic_ccg` instance and generates its `en`, `hyst` and `force_en` inputs. Requesting agents raise a level request and receive an acknowledge only once the gated clock is running and stable. The controller holds the clock on through an idle window before gating it off, and counts gating events for power-debug visibility.

## Interface
- `NUM_REQ`, 4, number of requesting agents (≥1)
- `IDLE_CYC`, 8, idle cycles required before the clock is gated (≥1)
- `WAKE_CYC`, 2, cycles the enable is held before acknowledging, covering the CCG's registered-enable latency (≥1)
- `clk`  in  1  free-running clock; the controller itself is never gated
- `rst_n`  in  1  reset, asynchronous, active-low
- `act_req`  in  NUM_REQ  per-agent level request for the gated clock
- `busy`  in  1  downstream in-flight work; blocks gating but produces no ack
- `force_on`  in  1  debug override that keeps the clock on
- `act_ack`  out  NUM_REQ  per-agent grant: gated clock is running
- `ccg_en`  out  1  to the CCG `en`
- `ccg_hyst`  out  1  to the CCG `hyst`
- `ccg_force_en`  out  1  to the CCG `force_en`
- `state`  out  2  FSM state: OFF=0, WAKE=1, ON=2, IDLE=3
- `gate_cnt`  out  16  count of ON→OFF gating events, saturating

## Operation
- **Activity terms**
  - `any_req` = OR of `act_req`.
  - `activity` = `any_req` | `busy` | `force_on`.
- **Single down-counter `cnt`**
  - Width is `$clog2(max(IDLE_CYC, WAKE_CYC)+1)`.
  - It is shared by the WAKE and IDLE states.
- **OFF**
  - `ccg_en`=0.
  - If `activity` is high: go to WAKE and load `cnt` = WAKE_CYC-1.
- **WAKE**
  - `ccg_en`=1.
  - If `cnt`==0: go to ON. Otherwise decrement `cnt`.
  - WAKE always completes, even if requests drop.
- **ON**
  - `ccg_en`=1.
  - If `activity` is low: go to IDLE and load `cnt` = IDLE_CYC-1.
- **IDLE**
  - `ccg_en`=1.
  - If `activity` is high: go to ON. No wake is needed because the clock is still running.
  - Else if `cnt`==0: go to OFF and increment `gate_cnt`.
  - Else decrement `cnt`.
  - When activity and `cnt`==0 occur in the same cycle, activity wins.
- **Output derivation**
  - `act_ack[i]` = `act_req[i]` & (state==ON). It is combinational from the state register.
  - `ccg_hyst` = (state==ON).
  - `ccg_en` = (state≠OFF). It is decoded from the state register, with no combinational path from the inputs.
  - `ccg_force_en` is `force_on` registered by one cycle.
- **`gate_cnt`**
  - Saturates at 0xFFFF.
  - It is cleared only by reset.
- **Reset**
  - Values: state=OFF, `cnt`=0, `gate_cnt`=0, `ccg_force_en`=0. Consequently `ccg_en`=0, `ccg_hyst`=0 and `act_ack`=0.
  - An assertion mid-operation takes effect immediately, from any state.

## Timing
- **Wake latency**
  - `act_req` rises at cycle T in OFF → WAKE and `ccg_en`=1 at T+1.
  - WAKE occupies T+1 through T+WAKE_CYC.
  - ON and `act_ack` at T+WAKE_CYC+1. With the default parameters, ack is at T+3.
- **Gating latency**
  - Last activity at T-1, so ON sees no activity at T → IDLE occupies T+1 through T+IDLE_CYC.
  - OFF, with `ccg_en`=0, at T+IDLE_CYC+1.
  - `gate_cnt` updates in that same cycle.
- **Re-request from IDLE**
  - `act_req` at cycle t → ON at t+1, with ack at t+1.
- **Ack/request behaviour**
  - `act_ack` falls in the same cycle as `act_req`.
  - Agents must hold `act_req` until they see `act_ack`.
- **`force_on`**
  - Asserted in OFF: follows the wake path, and `ccg_force_en` rises one cycle later.
  - Held: prevents IDLE→OFF indefinitely.
- **`busy` alone** keeps the FSM in ON or IDLE→ON, with `act_ack` all zero.

## Test plan
- **Reset:** hold `rst_n`=0 while inputs toggle → state=0, `ccg_en`=0, `act_ack`=0, `gate_cnt`=0. Release with `act_req`=0 → remains OFF.
- **Wake:** `act_req`=4'b0010 at T from OFF → `ccg_en`=1 at T+1, state=WAKE during T+1..T+2, `act_ack`=4'b0010 at T+3.
- **Gate:** drop `act_req` at T in ON → IDLE during T+1..T+8, state=OFF and `ccg_en`=0 at T+9, `gate_cnt`=1.
- **Re-request boundary:** `act_req`=1 arriving in the last IDLE cycle (`cnt`=0) → ON next cycle with ack, no gating event, `gate_cnt` unchanged.
- **Busy/force:** `busy`=1 in IDLE → ON with `act_ack`=0. `force_on`=1 for 50 cycles → no OFF entry, `ccg_force_en` follows with 1-cycle delay.
- **Saturation/async reset:** 65,536 gating cycles → `gate_cnt`=0xFFFF and holds. Async reset mid-WAKE → outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/ccg_en_ctrl.sv
// Enable controller for one clock-gate cell: wakes the gated clock on request,
// acknowledges once it is stable, and gates it after an idle window.
module ccg_en_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2,
  parameter int GCNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] act_req,
  input  logic               busy,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] act_ack,
  output logic               ccg_en,
  output logic               ccg_hyst,
  output logic               ccg_force_en,
  output logic [1:0]         state,
  output logic [GCNT_W-1:0]  gate_cnt
);

  localparam int MAX_CYC = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GCNT_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic                force_en_q, force_en_d;
  logic                activity;

  assign activity = (|act_req) | busy | force_on;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gate_cnt_d = gate_cnt_q;
    force_en_d = force_on;
    case (state_q)
      S_OFF: begin
        if (activity) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LD;
        end
      end
      // Wake always runs to completion so the CCG's registered enable settles.
      S_WAKE: begin
        if (cnt_q == '0) state_d = S_ON;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ON: begin
        if (!activity) begin
          state_d = S_IDLE;
          cnt_d   = IDLE_LD;
        end
      end
      // Activity beats expiry: the clock is still running, so go straight back to ON.
      S_IDLE: begin
        if (activity) begin
          state_d = S_ON;
        end else if (cnt_q == '0) begin
          state_d = S_OFF;
          if (gate_cnt_q != '1) gate_cnt_d = gate_cnt_q + GCNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      gate_cnt_q <= '0;
      force_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_cnt_q <= gate_cnt_d;
      force_en_q <= force_en_d;
    end
  end

  // All CCG controls decode from flops only, keeping input glitches off the gate.
  assign ccg_en       = (state_q != S_OFF);
  assign ccg_hyst     = (state_q == S_ON);
  assign ccg_force_en = force_en_q;
  assign act_ack      = act_req & {NUM_REQ{state_q == S_ON}};
  assign state        = state_q;
  assign gate_cnt     = gate_cnt_q;

endmodule

// File: tb/tb_ccg_en_ctrl.sv
// Directed bench for ccg_en_ctrl: default instance plus a narrow-counter
// instance with short windows to reach gate-count saturation quickly.
module tb_ccg_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  act_req;
  logic        busy, force_on;
  logic [3:0]  act_ack;
  logic        ccg_en, ccg_hyst, ccg_force_en;
  logic [1:0]  state;
  logic [15:0] gate_cnt;

  logic        req2;
  logic        ack2, en2, hyst2, force_en2;
  logic [1:0]  state2;
  logic [2:0]  gate_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ccg_en_ctrl #(.NUM_REQ(4), .IDLE_CYC(8), .WAKE_CYC(2), .GCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .act_req(act_req), .busy(busy), .force_on(force_on),
    .act_ack(act_ack), .ccg_en(ccg_en), .ccg_hyst(ccg_hyst),
    .ccg_force_en(ccg_force_en), .state(state), .gate_cnt(gate_cnt)
  );

  ccg_en_ctrl #(.NUM_REQ(1), .IDLE_CYC(1), .WAKE_CYC(1), .GCNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .act_req(req2), .busy(1'b0), .force_on(1'b0),
    .act_ack(ack2), .ccg_en(en2), .ccg_hyst(hyst2),
    .ccg_force_en(force_en2), .state(state2), .gate_cnt(gate_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; act_req = '0; busy = 1'b0; force_on = 1'b0; req2 = 1'b0;

    // reset held while inputs toggle
    act_req = 4'b1111; busy = 1'b1; force_on = 1'b1; req2 = 1'b1;
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_en", ccg_en, 0);
    check("rst_ack", act_ack, 0);
    check("rst_gate", gate_cnt, 0);
    check("rst_hyst", ccg_hyst, 0);
    check("rst_force_en", ccg_force_en, 0);
    act_req = '0; busy = 1'b0; force_on = 1'b0; req2 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", state, 0);
    check("post_rst_en", ccg_en, 0);

    // wake from OFF
    act_req = 4'b0010;
    tick();
    check("wake1_state", state, 1);
    check("wake1_en", ccg_en, 1);
    check("wake1_ack", act_ack, 0);
    tick();
    check("wake2_state", state, 1);
    tick();
    check("on_state", state, 2);
    check("on_ack", act_ack, 4'b0010);
    check("on_hyst", ccg_hyst, 1);

    // drop request: ack falls combinationally, then idle window and gate
    act_req = 4'b0000;
    #1;
    check("ack_fall", act_ack, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_state", state, 3);
      check("idle_en", ccg_en, 1);
    end
    tick();
    check("gated_state", state, 0);
    check("gated_en", ccg_en, 0);
    check("gated_cnt", gate_cnt, 1);

    // re-request in the last idle cycle
    act_req = 4'b0001;
    repeat (3) tick();
    check("rereq_on", state, 2);
    act_req = 4'b0000;
    repeat (8) tick();
    check("rereq_idle_last", state, 3);
    act_req = 4'b0001;
    tick();
    check("rereq_state", state, 2);
    check("rereq_ack", act_ack, 4'b0001);
    check("rereq_gate", gate_cnt, 1);

    // busy alone
    act_req = 4'b0000;
    tick();
    check("busy_pre_idle", state, 3);
    busy = 1'b1;
    tick();
    check("busy_on", state, 2);
    check("busy_ack", act_ack, 0);
    tick();
    check("busy_hold", state, 2);
    busy = 1'b0;
    tick();
    check("busy_drop_idle", state, 3);

    // force_on held for 50 cycles
    force_on = 1'b1;
    tick();
    check("force_on_state", state, 2);
    check("force_en_rise", ccg_force_en, 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("force_hold_state", state, 2);
      check("force_hold_en", ccg_force_en, 1);
    end
    force_on = 1'b0;
    tick();
    check("force_drop_idle", state, 3);
    check("force_en_fall", ccg_force_en, 0);
    repeat (7) tick();
    check("force_idle_last", state, 3);
    tick();
    check("force_gated", state, 0);
    check("force_gate_cnt", gate_cnt, 2);

    // force_on from OFF takes the wake path
    force_on = 1'b1;
    tick();
    check("fwake_state", state, 1);
    check("fwake_force_en", ccg_force_en, 1);
    force_on = 1'b0;
    tick();
    check("fwake2_state", state, 1);
    check("fwake2_force_en", ccg_force_en, 0);
    tick();
    check("fwake_on", state, 2);
    tick();
    check("fwake_idle", state, 3);
    repeat (7) tick();
    check("fwake_idle_last", state, 3);
    tick();
    check("fwake_gated", state, 0);
    check("fwake_gate_cnt", gate_cnt, 3);

    // async reset mid-WAKE, checked before any clock edge
    act_req = 4'b0100;
    tick();
    check("arst_pre_wake", state, 1);
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_en", ccg_en, 0);
    check("arst_gate", gate_cnt, 0);
    check("arst_ack", act_ack, 0);
    act_req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_release", state, 0);

    // narrow counter saturates and holds
    for (int i = 0; i < 10; i++) begin
      req2 = 1'b1;
      tick();
      tick();
      check("sat_on", state2, 2);
      req2 = 1'b0;
      tick();
      tick();
      check("sat_off", state2, 0);
      check("sat_cnt", gate_cnt2, (i + 1 > 7) ? 7 : i + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
